// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
// Holds the FSM state type and the default operand width.
package mult_pkg;

  // Default operand width in bits; the product is twice this wide.
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier.
// One partial-product step per clock; WIDTH steps per operation.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset
//   start    level-sampled request, accepted only in IDLE
//   a, b     unsigned multiplicand / multiplier, captured at the accepting edge
//   busy     high while a multiplication is in progress
//   done     one-cycle pulse marking a new product
//   product  a*b, held until the next result (or reset)
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [AW-1:0]    acc_step;
  logic [CW-1:0]    cnt_dec;
  logic             last;

  // Datapath step: add into the upper WIDTH+1 bits so the carry survives the shift.
  always_comb begin
    sum      = acc[AW-1:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = {sum, acc[WIDTH-1:0]} >> 1;
    cnt_dec  = cnt - CW'(1);
    last     = (cnt == CW'(1));
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All state; busy/done are registered from the current state, so they
  // trail the FSM by one cycle and can never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state == CALC);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt_dec;
          if (last) product <= acc_step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH = 8).
// A transaction-level model predicts busy/done/product every cycle from
// the accept edge and a*b; directed scenarios pin the model with literals.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Model: an operation accepted at edge 0 shows busy after edges 1..W,
  // the product from edge W on, and done after edge W+1; start is only
  // honoured when no operation is outstanding.
  logic        m_active   = 1'b0;
  int          m_age      = 0;
  logic [15:0] m_prod     = '0;
  logic        exp_busy   = 1'b0;
  logic        exp_done   = 1'b0;
  logic [15:0] exp_prod   = '0;
  logic        m_rst_seen = 1'b0;

  always @(posedge clk) begin
    m_rst_seen <= rst;
    if (!rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_prod <= '0;
    end else if (m_active) begin
      m_age    <= m_age + 1;
      exp_busy <= (m_age + 1 <= int'(W));
      exp_done <= (m_age + 1 == int'(W) + 1);
      if (m_age + 1 == int'(W))     exp_prod <= m_prod;
      if (m_age + 1 == int'(W) + 1) m_active <= 1'b0;
    end else begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      if (start) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_prod   <= {8'b0, a} * {8'b0, b};
      end
    end
  end

  // Per-cycle compare against the model plus structural properties.
  logic        chk_en      = 1'b0;
  logic        prev_done   = 1'b0;
  logic [15:0] prev_prod   = '0;
  logic        chg_pending = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(exp_busy));
      check("model_done", 32'(done), 32'(exp_done));
      check("model_product", 32'(product), 32'(exp_prod));
      check("busy_done_excl", 32'(busy && done), 32'(0));
      if (prev_done) check("done_one_cycle", 32'(done), 32'(0));
      if (chg_pending) check("product_change_then_done", 32'(done), 32'(1));
      chg_pending <= (product !== prev_prod) && m_rst_seen;
      prev_prod   <= product;
      prev_done   <= done;
    end
  end

  // Launch one operation from a negedge and wait for its done pulse.
  task automatic do_mult(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] exp_p);
    int lat;
    int nb;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    nb    = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end
    check({name, "_latency"}, 32'(lat), 32'(9));
    check({name, "_busy_cycles"}, 32'(nb), 32'(8));
    check({name, "_product"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int ndone;
    int hold_bad;
    int d_idx[2];
    logic [15:0] d_prod[2];

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_product", 32'(product), 32'(0));
    rst = 1'b1;

    // Basic and extremes (start accepted right after reset release)
    do_mult("basic_0c_0a", 8'h0C, 8'h0A, 16'h0078);
    do_mult("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    do_mult("00_ff", 8'h00, 8'hFF, 16'h0000);
    do_mult("80_02", 8'h80, 8'h02, 16'h0100);
    do_mult("a5_5a", 8'hA5, 8'h5A, 16'h3A02);

    // Ignore start/operand changes during CALC, then hold
    @(negedge clk);
    a = 8'h03; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) begin a = 8'h11; start = 1'b1; end
      else if (i == 4) start = 1'b0;
      if (done) ndone++;
    end
    check("ignore_done_count", 32'(ndone), 32'(1));
    check("ignore_product", 32'(product), 32'(16'h000F));
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (product !== 16'h000F || done) hold_bad++;
    end
    check("hold_20_idle", 32'(hold_bad), 32'(0));

    // Reset in the 4th CALC cycle aborts the operation
    a = 8'h07; b = 8'h06; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_product", 32'(product), 32'(0));
    rst = 1'b1;
    do_mult("after_reset_02_03", 8'h02, 8'h03, 16'h0006);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h10;
    ndone = 0;
    d_idx[0] = 0; d_idx[1] = 0;
    d_prod[0] = '0; d_prod[1] = '0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 2) begin
          d_idx[ndone]  = i;
          d_prod[ndone] = product;
        end
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'(2));
    check("b2b_first_latency", 32'(d_idx[0]), 32'(9));
    check("b2b_spacing", 32'(d_idx[1] - d_idx[0]), 32'(10));
    check("b2b_first_product", 32'(d_prod[0]), 32'(16'h0001));
    check("b2b_second_product", 32'(d_prod[1]), 32'(16'h0100));
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
